// File: rtl/sdram_chip_model.sv
// SDR SDRAM device model: decodes CS/RAS/CAS/WE, tracks open rows per bank, serves byte-masked bursts.
// Latency: read beat n is on dq for the controller edge CL+n after READ; write beat n is taken n edges after WRITE.
// Backpressure: none; cke=0 freezes command decode, burst counter, read pipeline and outputs.
module sdram_chip_model #(
  parameter int ROW_W        = 13,
  parameter int COL_W        = 10,
  parameter int MEM_ROW_BITS = 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             sdram_cke,
  input  logic             sdram_cs,
  input  logic             sdram_ras,
  input  logic             sdram_cas,
  input  logic             sdram_we,
  input  logic [ROW_W-1:0] sdram_a,
  input  logic [1:0]       sdram_ba,
  input  logic [3:0]       sdram_dqm,
  input  logic [31:0]      sdram_dq_i,
  output logic [31:0]      sdram_dq_o,
  output logic             sdram_dq_oe,
  output logic [3:0]       bank_open_o,
  output logic             err_o
);

  localparam int AW    = 2 + MEM_ROW_BITS + COL_W;
  localparam int DEPTH = 1 << AW;

  typedef logic [AW-1:0] addr_t;
  typedef enum logic [1:0] {
    BURST_IDLE  = 2'd0,
    BURST_READ  = 2'd1,
    BURST_WRITE = 2'd2
  } burst_t;

  // Storage is never reset, like a real device.
  logic [31:0] mem [DEPTH];

  // Bank / mode state
  logic [3:0]              bank_open;
  logic [MEM_ROW_BITS-1:0] open_row [4];
  logic [3:0]              bl_len;      // 1, 2, 4 or 8
  logic                    cl3;         // 1 => CAS latency 3, else 2

  // Active burst
  burst_t                  burst_st;
  logic [1:0]              burst_ba;
  logic [MEM_ROW_BITS-1:0] burst_row;
  logic [COL_W-1:0]        burst_c;     // starting column of the burst
  logic [3:0]              burst_n;     // index of the next beat to issue
  logic [3:0]              burst_bl;

  // Read pipeline: stage 0 for CL2, stage 1 for CL3, then the dq_o register
  logic [1:0]              rd_vld;
  addr_t                   rd_addr [2];

  // Row bits above MEM_ROW_BITS alias onto the stored rows and are dropped.
  logic unused_a;
  assign unused_a = ^sdram_a;

  // Command decode; cke=0 turns every command into a NOP.
  logic [3:0] cmd;
  logic is_act, is_rd, is_wr, is_pre, is_ref, is_lmr, is_bst;
  assign cmd    = {sdram_cs, sdram_ras, sdram_cas, sdram_we};
  assign is_act = sdram_cke && (cmd == 4'b0011);
  assign is_rd  = sdram_cke && (cmd == 4'b0101);
  assign is_wr  = sdram_cke && (cmd == 4'b0100);
  assign is_pre = sdram_cke && (cmd == 4'b0010);
  assign is_ref = sdram_cke && (cmd == 4'b0001);
  assign is_lmr = sdram_cke && (cmd == 4'b0000);
  assign is_bst = sdram_cke && (cmd == 4'b0110);

  // Beat issue: a fresh READ/WRITE to an open bank wins over a running burst.
  logic             bank_hit, new_rw, cont, issue, issue_rd, pre_hit, busy;
  logic [1:0]       issue_ba;
  logic [MEM_ROW_BITS-1:0] issue_row;
  logic [COL_W-1:0] issue_c, issue_mask, issue_col;
  logic [3:0]       issue_n, issue_bl;
  addr_t            issue_addr;
  logic             rd_beat, wr_beat;
  logic             src_vld;
  addr_t            src_addr;

  assign bank_hit   = bank_open[sdram_ba];
  assign new_rw     = (is_rd || is_wr) && bank_hit;
  assign cont       = sdram_cke && (burst_st != BURST_IDLE) && !is_bst && !new_rw;
  assign issue      = new_rw || cont;
  assign issue_rd   = new_rw ? is_rd : (burst_st == BURST_READ);
  assign issue_ba   = new_rw ? sdram_ba : burst_ba;
  assign issue_row  = new_rw ? open_row[sdram_ba] : burst_row;
  assign issue_c    = new_rw ? sdram_a[COL_W-1:0] : burst_c;
  assign issue_n    = new_rw ? 4'd0 : burst_n;
  assign issue_bl   = new_rw ? bl_len : burst_bl;
  // Columns wrap inside the BL-aligned block.
  assign issue_mask = COL_W'(issue_bl - 4'd1);
  assign issue_col  = (issue_c & ~issue_mask) | ((issue_c + COL_W'(issue_n)) & issue_mask);
  assign issue_addr = {issue_ba, issue_row, issue_col};
  assign rd_beat    = issue && issue_rd;
  assign wr_beat    = issue && !issue_rd;
  assign pre_hit    = is_pre && (sdram_a[10] || (sdram_ba == burst_ba));
  assign busy       = (burst_st != BURST_IDLE) || (|rd_vld);

  assign src_vld    = cl3 ? rd_vld[1]  : rd_vld[0];
  assign src_addr   = cl3 ? rd_addr[1] : rd_addr[0];

  assign bank_open_o = bank_open;

  // Bank rows, mode register and the sticky protocol error flag.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      bank_open <= '0;
      for (int i = 0; i < 4; i++) open_row[i] <= '0;
      bl_len    <= 4'd1;
      cl3       <= 1'b0;
      err_o     <= 1'b0;
    end else if (sdram_cke) begin
      if (is_act) begin
        open_row[sdram_ba]  <= sdram_a[MEM_ROW_BITS-1:0];
        bank_open[sdram_ba] <= 1'b1;
        if (bank_open[sdram_ba]) err_o <= 1'b1;
      end
      if (is_pre) begin
        if (sdram_a[10]) bank_open <= '0;
        else             bank_open[sdram_ba] <= 1'b0;
      end
      if (is_ref && (|bank_open)) err_o <= 1'b1;
      if ((is_rd || is_wr) && !bank_hit) err_o <= 1'b1;
      if (is_lmr) begin
        case (sdram_a[2:0])
          3'd1:    bl_len <= 4'd2;
          3'd2:    bl_len <= 4'd4;
          3'd3:    bl_len <= 4'd8;
          default: bl_len <= 4'd1;
        endcase
        cl3 <= (sdram_a[6:4] == 3'd3);
        if (busy) err_o <= 1'b1;
      end
    end
  end

  // Burst sequencer: start, advance, truncate on BST or on precharge of its bank.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      burst_st  <= BURST_IDLE;
      burst_ba  <= '0;
      burst_row <= '0;
      burst_c   <= '0;
      burst_n   <= '0;
      burst_bl  <= 4'd1;
    end else if (new_rw) begin
      if (bl_len == 4'd1) burst_st <= BURST_IDLE;
      else                burst_st <= is_rd ? BURST_READ : BURST_WRITE;
      burst_ba  <= sdram_ba;
      burst_row <= open_row[sdram_ba];
      burst_c   <= sdram_a[COL_W-1:0];
      burst_n   <= 4'd1;
      burst_bl  <= bl_len;
    end else if (cont) begin
      burst_n <= burst_n + 4'd1;
      if ((burst_n == burst_bl - 4'd1) || pre_hit) burst_st <= BURST_IDLE;
    end else if (is_bst) begin
      burst_st <= BURST_IDLE;
    end
  end

  // Read pipeline and registered dq; a write beat flushes pending read beats.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rd_vld      <= '0;
      rd_addr[0]  <= '0;
      rd_addr[1]  <= '0;
      sdram_dq_o  <= '0;
      sdram_dq_oe <= 1'b0;
    end else if (sdram_cke) begin
      rd_vld[0]  <= rd_beat;
      rd_addr[0] <= issue_addr;
      rd_vld[1]  <= rd_vld[0] && !wr_beat;
      rd_addr[1] <= rd_addr[0];
      if (wr_beat || !src_vld) begin
        sdram_dq_oe <= 1'b0;
        sdram_dq_o  <= '0;
      end else begin
        sdram_dq_oe <= 1'b1;
        sdram_dq_o  <= mem[src_addr];
      end
    end
  end

  // Byte-masked write of the current write beat into storage.
  always_ff @(posedge clock) begin
    if (wr_beat) begin
      for (int i = 0; i < 4; i++) begin
        if (!sdram_dqm[i]) mem[issue_addr][8*i +: 8] <= sdram_dq_i[8*i +: 8];
      end
    end
  end

endmodule
